// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the store buffer and its FIFO:
//   - request size encodings (SZ_B / SZ_H / SZ_W; 2'b11 is reserved)
//   - default geometry (DEF_DEPTH entries, DEF_AW word-index bits)
//   - sb_entry_t, one buffered store: word index, byte enables, lane data
//   - lane_merge(), which overlays enabled byte lanes onto a base word
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 5;

  // The index field is wide enough for any word index of a 32-bit byte
  // address. Bits above AW are always zero, so comparing the whole field
  // is the same as comparing the low AW bits.
  localparam int IDX_W = 30;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      data;
  } sb_entry_t;

  localparam int ENTRY_W = $bits(sb_entry_t);

  // Replace each byte lane of base whose enable bit is set with the
  // matching lane of data.
  function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                             input logic [3:0]  be,
                                             input logic [31:0] data);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = data[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = base[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// Circular store-buffer storage. The pointers are one bit wider than the slot
// index so that a full buffer can be told apart from an empty one.
// Ports:
//   CLK, Resetn : clock and asynchronous active-low reset
//   push, din   : enqueue an entry at the tail (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : the oldest entry
//   all_ord     : every slot, flattened; slot 0 is the oldest
//   all_vld     : occupancy mask matching all_ord
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module sb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       CLK,
  input  logic                       Resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         din,
  output logic [ENTRY_W-1:0]         head,
  output logic [DEPTH*ENTRY_W-1:0]   all_ord,
  output logic [DEPTH-1:0]           all_vld,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] store_r [DEPTH];
  logic [PW:0]        wr_ptr_r;
  logic [PW:0]        rd_ptr_r;
  logic [PW:0]        occ_s;
  logic               do_push_s;
  logic               do_pop_s;
  logic [PW-1:0]      slot_s;

  assign occ_s     = wr_ptr_r - rd_ptr_r;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                     (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = store_r[rd_ptr_r[PW-1:0]];

  // Pointer update: the pointers wrap naturally, and the extra MSB records
  // which lap each pointer is on.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // Entry storage: cleared on reset, so no stale store survives it.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_r[i] <= '0;
      end
    end else if (do_push_s) begin
      store_r[wr_ptr_r[PW-1:0]] <= din;
    end
  end

  // Present every slot oldest-first so that forwarding can overlay entries
  // in program order.
  always_comb begin
    all_ord = '0;
    all_vld = '0;
    slot_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = rd_ptr_r[PW-1:0] + PW'(i);
      all_ord[i*ENTRY_W +: ENTRY_W] = store_r[slot_s];
      all_vld[i] = ((PW+1)'(i) < occ_s);
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer
// Posted-store buffer and load/store unit that sits in front of a word-wide
// data memory. Stores are queued and later drained to memory with a
// read-modify-write. Loads read memory, pick up any bytes still waiting in
// the buffer, and return an extended result one cycle later.
// Ports:
//   CLK, Resetn       : clock and asynchronous active-low reset
//   req_*             : pipeline request (valid, wr, addr, size, unsigned, wdata)
//   stall             : request not accepted this cycle (buffer full)
//   ld_valid, ld_data : registered load result
//   misalign          : registered flag for a rejected misaligned request
//   empty             : no stores pending
//   mem_RA, mem_WA    : memory read and write word addresses
//   mem_Di, mem_MemWr : merged write data and write enable
//   mem_Do            : asynchronous memory read data
// -----------------------------------------------------------------------------
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic        CLK,
  input  logic        Resetn,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        empty,
  output logic [31:0] mem_RA,
  output logic [31:0] mem_WA,
  output logic [31:0] mem_Di,
  output logic        mem_MemWr,
  input  logic [31:0] mem_Do
);

  logic [1:0]               off_s;
  logic [IDX_W-1:0]         req_idx_s;
  logic [31-(AW+2):0]       unused_addr_s;
  logic [3:0]               be_s;
  logic [31:0]              lane_data_s;
  logic                     mis_s;
  logic                     full_s;
  logic                     empty_s;
  logic                     acc_s;
  logic                     push_s;
  logic                     ld_acc_s;
  logic                     drain_s;
  sb_entry_t                new_ent_s;
  sb_entry_t                head_s;
  sb_entry_t                ent_s;
  logic [ENTRY_W-1:0]       head_bits_s;
  logic [DEPTH*ENTRY_W-1:0] all_ord_s;
  logic [DEPTH-1:0]         all_vld_s;
  logic [31:0]              fwd_word_s;
  logic [31:0]              shifted_s;
  logic [31:0]              ext_s;
  logic                     ld_valid_r;
  logic [31:0]              ld_data_r;
  logic                     misalign_r;

  assign off_s         = req_addr[1:0];
  assign req_idx_s     = {{(IDX_W-AW){1'b0}}, req_addr[AW+1:2]};
  assign unused_addr_s = req_addr[31:AW+2];

  // Decode size: byte enables, lane-replicated data and alignment check.
  // Replicating the data across lanes lets the byte enables alone pick the
  // right lanes, so no data shifter is needed.
  always_comb begin
    be_s        = 4'b0000;
    lane_data_s = 32'h0000_0000;
    mis_s       = 1'b0;
    case (req_size)
      SZ_B: begin
        be_s        = 4'b0001 << off_s;
        lane_data_s = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be_s        = 4'b0011 << off_s;
        lane_data_s = {2{req_wdata[15:0]}};
        mis_s       = off_s[0];
      end
      SZ_W: begin
        be_s        = 4'b1111;
        lane_data_s = req_wdata;
        mis_s       = (off_s != 2'b00);
      end
      default: begin
        mis_s = 1'b1;
      end
    endcase
  end

  // Arbitration. While the buffer is full no load can be accepted, so the
  // drain always wins and the stalled request is accepted the next cycle.
  assign stall    = req_valid & full_s;
  assign acc_s    = req_valid & ~full_s & ~mis_s;
  assign push_s   = acc_s & req_wr;
  assign ld_acc_s = acc_s & ~req_wr;
  assign drain_s  = ~empty_s & (~ld_acc_s | full_s);
  assign empty    = empty_s;

  assign new_ent_s.idx  = req_idx_s;
  assign new_ent_s.be   = be_s;
  assign new_ent_s.data = lane_data_s;
  assign head_s         = head_bits_s;

  sb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .Resetn (Resetn),
    .push   (push_s),
    .pop    (drain_s),
    .din    (new_ent_s),
    .head   (head_bits_s),
    .all_ord(all_ord_s),
    .all_vld(all_vld_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  // Store-to-load forwarding: overlay every pending store to the same word,
  // oldest first, so the youngest store wins on each byte.
  always_comb begin
    fwd_word_s = mem_Do;
    ent_s      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_s = all_ord_s[i*ENTRY_W +: ENTRY_W];
      if (all_vld_s[i] && (ent_s.idx == req_idx_s)) begin
        fwd_word_s = lane_merge(fwd_word_s, ent_s.be, ent_s.data);
      end else begin
        fwd_word_s = fwd_word_s;
      end
    end
  end

  // Move the addressed lanes down to bit 0, then zero- or sign-extend them.
  always_comb begin
    shifted_s = fwd_word_s >> {off_s, 3'b000};
    ext_s     = 32'h0000_0000;
    case (req_size)
      SZ_B: ext_s = req_unsigned ? {24'h00_0000, shifted_s[7:0]}
                                 : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_H: ext_s = req_unsigned ? {16'h0000, shifted_s[15:0]}
                                 : {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_W: ext_s = shifted_s;
      default: ext_s = 32'h0000_0000;
    endcase
  end

  // Memory port steering: the read port serves the drain or the load. The
  // read address is held at zero during reset even if a request is present.
  always_comb begin
    mem_RA    = 32'h0000_0000;
    mem_WA    = 32'h0000_0000;
    mem_Di    = 32'h0000_0000;
    mem_MemWr = 1'b0;
    if (drain_s) begin
      mem_RA    = {2'b00, head_s.idx};
      mem_WA    = {2'b00, head_s.idx};
      mem_Di    = lane_merge(mem_Do, head_s.be, head_s.data);
      mem_MemWr = 1'b1;
    end else if (ld_acc_s && Resetn) begin
      mem_RA = {2'b00, req_idx_s};
    end else begin
      mem_RA = 32'h0000_0000;
    end
  end

  // Registered load result and misalignment flag. A request held by a
  // stall is not flagged, because it will be presented again.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      ld_valid_r <= 1'b0;
      ld_data_r  <= 32'h0000_0000;
      misalign_r <= 1'b0;
    end else begin
      ld_valid_r <= ld_acc_s;
      misalign_r <= req_valid & ~full_s & mis_s;
      if (ld_acc_s) begin
        ld_data_r <= ext_s;
      end else begin
        ld_data_r <= ld_data_r;
      end
    end
  end

  assign ld_valid = ld_valid_r;
  assign ld_data  = ld_data_r;
  assign misalign = misalign_r;

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 5;

  logic        CLK = 1'b0;
  logic        Resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, ld_valid, misalign, empty, mem_MemWr;
  logic [31:0] ld_data, mem_RA, mem_WA, mem_Di, mem_Do;

  mem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .Resetn(Resetn), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .misalign(misalign), .empty(empty), .mem_RA(mem_RA), .mem_WA(mem_WA),
    .mem_Di(mem_Di), .mem_MemWr(mem_MemWr), .mem_Do(mem_Do)
  );

  always #5 CLK = ~CLK;

  // memory environment: async read, write at negedge
  logic [31:0] init_val [32];
  logic [31:0] env_mem  [32];
  logic        init_done = 1'b0;
  assign mem_Do = env_mem[mem_RA[4:0]];

  always @(negedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val[i];
      init_done <= 1'b1;
    end else if (mem_MemWr) begin
      env_mem[mem_WA[4:0]] <= mem_Di;
    end
  end

  // reference model: memory contents plus an ordered list of pending stores
  typedef struct packed {
    logic [4:0]  idx;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;
  ent_t        q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] exp_ld_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one cycle: called at posedge+1, returns at the next posedge+1
  task automatic cyc(input logic v, input logic wr, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    int n, off;
    logic mis, full_e, acc, ld, drain;
    logic [4:0]  idx;
    logic [31:0] word, val, mask, merged;
    ent_t h, e;
    req_valid = v; req_wr = wr; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    #1;
    off = int'(addr[1:0]);
    idx = addr[6:2];
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (size == 2'd3) || ((off % n) != 0);
    full_e = (q.size() == DEPTH);
    acc    = v && !full_e && !mis;
    ld     = acc && !wr;
    drain  = (q.size() != 0) && (!ld || full_e);
    merged = 32'h0;
    h      = '0;
    chk("stall", {31'h0, stall}, {31'h0, v && full_e});
    chk("memwr", {31'h0, mem_MemWr}, {31'h0, drain});
    if (drain) begin
      h = q[0];
      merged = ref_mem[h.idx];
      for (int b = 0; b < 4; b++)
        if (h.be[b]) merged[8*b +: 8] = h.data[8*b +: 8];
      chk("wa", mem_WA, {27'h0, h.idx});
      chk("ra_drain", mem_RA, {27'h0, h.idx});
      chk("di", mem_Di, merged);
    end else begin
      chk("di_idle", mem_Di, 32'h0);
    end
    if (ld) begin
      chk("ra_load", mem_RA, {27'h0, idx});
      word = ref_mem[idx];
      foreach (q[i])
        if (q[i].idx == idx)
          for (int b = 0; b < 4; b++)
            if (q[i].be[b]) word[8*b +: 8] = q[i].data[8*b +: 8];
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
      val  = (word >> (8*off)) & mask;
      if (!uns && n < 4 && val[8*n-1]) val = val | ~mask;
      exp_ld_data = val;
    end
    @(posedge CLK); #1;
    if (drain) begin
      ref_mem[h.idx] = merged;
      void'(q.pop_front());
    end
    if (acc && wr) begin
      e = '0;
      e.idx = idx;
      for (int k = 0; k < n; k++) begin
        e.be[off+k] = 1'b1;
        e.data[8*(off+k) +: 8] = wdata[8*k +: 8];
      end
      q.push_back(e);
    end
    chk("ld_valid", {31'h0, ld_valid}, {31'h0, ld});
    if (ld) chk("ld_data", ld_data, exp_ld_data);
    chk("misalign", {31'h0, misalign}, {31'h0, v && !full_e && mis});
    chk("empty", {31'h0, empty}, {31'h0, q.size() == 0});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) init_val[i] = $urandom;
    init_val[1] = 32'h1122_3344;
    init_val[3] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val[i];
    exp_ld_data = 32'h0;

    // reset state
    #2;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_ldv", {31'h0, ld_valid}, 32'h0);
    chk("rst_ldd", ld_data, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_memwr", {31'h0, mem_MemWr}, 32'h0);
    chk("rst_ra", mem_RA, 32'h0);
    chk("rst_wa", mem_WA, 32'h0);
    chk("rst_di", mem_Di, 32'h0);
    @(posedge CLK); @(posedge CLK); #1;
    Resetn = 1'b1;

    // byte store then idle drain
    cyc(1'b1, 1'b1, 32'h05, 2'b00, 1'b0, 32'h0000_00AB);
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    chk("t1_mem", env_mem[1], 32'h1122_AB44);
    chk("t1_empty", {31'h0, empty}, 32'h1);

    // word store, signed byte load forwarded
    cyc(1'b1, 1'b1, 32'h08, 2'b10, 1'b0, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 32'h0B, 2'b00, 1'b0, 32'h0);
    chk("t2_ld", ld_data, 32'hFFFF_FFDE);
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);

    // youngest store wins
    cyc(1'b1, 1'b1, 32'h0C, 2'b01, 1'b0, 32'h0000_1234);
    cyc(1'b1, 1'b1, 32'h0C, 2'b00, 1'b0, 32'h0000_0099);
    cyc(1'b1, 1'b0, 32'h0C, 2'b10, 1'b1, 32'h0);
    chk("t3_ld", ld_data, 32'h0000_1299);
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);

    // misaligned half load
    cyc(1'b1, 1'b0, 32'h03, 2'b01, 1'b0, 32'h0);
    chk("t4_mis", {31'h0, misalign}, 32'h1);
    chk("t4_ldv", {31'h0, ld_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);

    // reset with a pending store
    cyc(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFE_F00D);
    Resetn = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t5_empty", {31'h0, empty}, 32'h1);
    chk("t5_memwr", {31'h0, mem_MemWr}, 32'h0);
    q.delete();
    exp_ld_data = 32'h0;
    @(posedge CLK); @(posedge CLK); #1;
    chk("t5_ldd", ld_data, 32'h0);
    Resetn = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    chk("t5_mem", env_mem[4], init_val[4]);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end
    for (int t = 0; t < 4; t++) cyc(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    for (int i = 0; i < 32; i++) chk("final_mem", env_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
